// File: rtl/pro3_do_reader.sv
// ============================================================================
// Module   : pro3_do_reader
// Purpose  : Receive-side companion to the Pro_3 data register. Captures each
//            new DO word into a small FIFO and, when the CHECK_EN macro is
//            defined, checks DO against a reference model of the register.
// Options  : `define CHECK_EN  -> enables the exp/armed checker (ERR, ERR_CNT)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pro3_do_reader #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clka,
  input  logic                   RESTART,
  input  logic                   LOAD,
  input  logic                   NOT,
  input  logic [WIDTH-1:0]       DATA,
  input  logic [WIDTH-1:0]       DO,
  input  logic                   RD,
  output logic [WIDTH-1:0]       Q,
  output logic                   EMPTY,
  output logic                   FULL,
  output logic [$clog2(DEPTH):0] CNT,
  output logic                   OVF,
  output logic [1:0]             r_state,
  output logic                   ERR,
  output logic [3:0]             ERR_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SYNC = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  state_t            state_q;
  logic              first_q;   // first RUN cycle: push regardless of last_do
  logic              ovf_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              empty_q;
  logic              full_q;
  logic [WIDTH-1:0]  last_do_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              pop;
  logic              push_req;
  logic              push_ok;
  logic              ovf_evt;

  // Push/pop qualification and next occupancy; a full FIFO still accepts a
  // push when the same edge pops the head.
  always_comb begin
    pop      = RD && !empty_q;
    push_req = (state_q == ST_RUN) && (first_q || (DO != last_do_q));
    push_ok  = push_req && (!full_q || pop);
    ovf_evt  = push_req && full_q && !pop;
    cnt_d    = cnt_q;
    if (push_ok && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_ok && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Reader state machine with registered first-push and sticky overflow flags.
  always_ff @(posedge clka) begin
    if (RESTART) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_SYNC;
        ST_SYNC: begin
          if (LOAD) begin
            state_q <= ST_RUN;
            first_q <= 1'b1;
          end
        end
        ST_RUN: begin
          first_q <= 1'b0;
          if (ovf_evt) begin
            ovf_q   <= 1'b1;
            state_q <= ST_HALT;
          end
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy, registered flags and last pushed word.
  always_ff @(posedge clka) begin
    if (RESTART) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      last_do_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q  <= wr_ptr_q + 1'b1;
        last_do_q <= DO;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == C_DEPTH);
    end
  end

  // Storage array; stale contents are masked by EMPTY so no reset is needed.
  always_ff @(posedge clka) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= DO;
    end
  end

  assign Q       = empty_q ? '0 : mem_q[rd_ptr_q];
  assign EMPTY   = empty_q;
  assign FULL    = full_q;
  assign CNT     = cnt_q;
  assign OVF     = ovf_q;
  assign r_state = state_q;

`ifdef CHECK_EN
  logic [WIDTH-1:0] exp_q;
  logic             armed_q;
  logic             err_q;
  logic [3:0]       err_cnt_q;

  // Reference model of the register; compares DO one cycle after the
  // expectation was formed and is frozen while in IDLE.
  always_ff @(posedge clka) begin
    if (RESTART) begin
      exp_q     <= '0;
      armed_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (state_q != ST_IDLE) begin
      if (armed_q && (DO != exp_q)) begin
        err_q <= 1'b1;
        if (err_cnt_q != 4'hF) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
      end
      if (LOAD) begin
        exp_q   <= DATA;
        armed_q <= 1'b1;
      end else if (NOT) begin
        exp_q <= ~exp_q;
      end
    end
  end

  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;
`else
  // Checker absent: its inputs are only sunk here.
  logic unused_chk;
  assign unused_chk = ^{NOT, DATA};
  assign ERR        = 1'b0;
  assign ERR_CNT    = 4'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pro3_do_reader.sv
// ============================================================================
// Module   : tb_pro3_do_reader
// Purpose  : Scoreboard bench for pro3_do_reader; a Pro_3 register model
//            drives DO, a behavioural reader model predicts flags and queues
//            expected words, and a monitor compares every popped word.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pro3_do_reader;

  localparam int WIDTH   = 4;
  localparam int DEPTH   = 4;
  localparam int ST_IDLE = 0;
  localparam int ST_SYNC = 1;
  localparam int ST_RUN  = 2;
  localparam int ST_HALT = 3;

  logic             clka = 1'b0;
  logic             RESTART = 1'b1;
  logic             LOAD = 1'b0;
  logic             NOT = 1'b0;
  logic [WIDTH-1:0] DATA = '0;
  logic [WIDTH-1:0] DO = '0;
  logic             RD = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             EMPTY;
  logic             FULL;
  logic [2:0]       CNT;
  logic             OVF;
  logic [1:0]       r_state;
  logic             ERR;
  logic [3:0]       ERR_CNT;

  int checks = 0;
  int errors = 0;

  // Expected words in capture order; monitor pops them as the DUT pops.
  logic [WIDTH-1:0] sb[$];

  // Behavioural reader model
  int               m_st    = ST_IDLE;
  bit               m_first = 1'b0;
  logic [WIDTH-1:0] m_last  = '0;
  int               m_cnt   = 0;
  bit               m_ovf   = 1'b0;
  logic [WIDTH-1:0] m_exp   = '0;
  bit               m_armed = 1'b0;
  bit               m_err   = 1'b0;
  int               m_ecnt  = 0;

  // Pro_3 register model producing DO
  logic [WIDTH-1:0] p3 = '0;

  pro3_do_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clka    (clka),
    .RESTART (RESTART),
    .LOAD    (LOAD),
    .NOT     (NOT),
    .DATA    (DATA),
    .DO      (DO),
    .RD      (RD),
    .Q       (Q),
    .EMPTY   (EMPTY),
    .FULL    (FULL),
    .CNT     (CNT),
    .OVF     (OVF),
    .r_state (r_state),
    .ERR     (ERR),
    .ERR_CNT (ERR_CNT)
  );

  always #5 clka = ~clka;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT is about to pop, its head must match the
  // oldest expected word.
  always @(negedge clka) begin
    logic [WIDTH-1:0] e;
    if (!RESTART && RD && !EMPTY) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_q: got %0h expected no word (nothing captured) at %0t", Q, $time);
      end else begin
        e = sb.pop_front();
        chk("pop_q", Q, e);
      end
    end
  end

  // Apply the reader rules to the inputs sampled at this edge.
  task automatic model_edge();
    int  pre;
    bit  pop;
    bit  want;
    pre = m_st;
    if (RESTART) begin
      m_st = ST_IDLE; m_first = 0; m_last = '0; m_cnt = 0; m_ovf = 0;
      m_exp = '0; m_armed = 0; m_err = 0; m_ecnt = 0;
      sb.delete();
    end else begin
      pop = RD && (m_cnt > 0);
      if (pre == ST_IDLE) begin
        m_st = ST_SYNC;
      end else if (pre == ST_SYNC) begin
        if (LOAD) begin
          m_st    = ST_RUN;
          m_first = 1;
        end
      end else if (pre == ST_RUN) begin
        want    = m_first || (DO != m_last);
        m_first = 0;
        if (want) begin
          if (m_cnt < DEPTH || pop) begin
            sb.push_back(DO);
            m_last = DO;
            m_cnt  = m_cnt + 1;
          end else begin
            m_ovf = 1;
            m_st  = ST_HALT;
          end
        end
      end
      if (pop) m_cnt = m_cnt - 1;
`ifdef CHECK_EN
      if (pre != ST_IDLE) begin
        if (m_armed && (DO != m_exp)) begin
          m_err = 1;
          if (m_ecnt < 15) m_ecnt = m_ecnt + 1;
        end
        if (LOAD) begin
          m_exp   = DATA;
          m_armed = 1;
        end else if (NOT) begin
          m_exp = ~m_exp;
        end
      end
`endif
    end
  endtask

  task automatic check_outputs();
    chk("cnt", CNT, m_cnt);
    chk("empty", EMPTY, (m_cnt == 0));
    chk("full", FULL, (m_cnt == DEPTH));
    chk("ovf", OVF, m_ovf);
    chk("state", r_state, m_st);
    chk("err", ERR, m_err);
    chk("err_cnt", ERR_CNT, m_ecnt);
    if (m_cnt == 0) chk("q_empty", Q, 0);
    else if (sb.size() > 0) chk("q_head", Q, sb[0]);
  endtask

  // One clock: drive inputs, run models at the edge, check 1 ns later.
  task automatic step(input bit rst, input bit ld, input bit nt,
                      input logic [WIDTH-1:0] dat, input bit rd,
                      input logic [WIDTH-1:0] corrupt);
    RESTART = rst;
    LOAD    = ld;
    NOT     = nt;
    DATA    = dat;
    RD      = rd;
    DO      = p3 ^ corrupt;
    @(posedge clka);
    model_edge();
    if (ld) p3 = dat;
    else if (nt) p3 = ~p3;
    #1;
    check_outputs();
  endtask

  task automatic drain(input int max_pops);
    for (int i = 0; i < max_pops; i++) step(0, 0, 0, '0, 1, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit               rst;
    logic [WIDTH-1:0] cor;

    // Reset with random control inputs
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), '0);

    // Basic capture: LOAD 5, first push, then DO held
    step(0, 1, 0, 4'h5, 0, '0);
    step(0, 1, 0, 4'h5, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 0, '0);

    // Invert sequence 5 -> A -> 5, then drain three words
    step(0, 0, 1, '0, 0, '0);
    step(0, 0, 1, '0, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    drain(3);

    // Overflow: 1,2,3,4 stored, 6 dropped
    step(1, 0, 0, '0, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    step(0, 1, 0, 4'h1, 0, '0);
    step(0, 1, 0, 4'h2, 0, '0);
    step(0, 1, 0, 4'h3, 0, '0);
    step(0, 1, 0, 4'h4, 0, '0);
    step(0, 1, 0, 4'h6, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    step(0, 1, 0, 4'h9, 0, '0);
    drain(5);

    // Full FIFO with simultaneous push and pop
    step(1, 0, 0, '0, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    step(0, 1, 0, 4'h1, 0, '0);
    step(0, 1, 0, 4'h2, 0, '0);
    step(0, 1, 0, 4'h3, 0, '0);
    step(0, 1, 0, 4'h4, 0, '0);
    step(0, 1, 0, 4'h7, 0, '0);
    step(0, 0, 0, '0, 1, '0);
    drain(5);

    // Checker: LOAD 3, DO forced to 4, then NOT with DO=C
    step(1, 0, 0, '0, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    step(0, 1, 0, 4'h3, 0, '0);
    step(0, 0, 1, '0, 0, 4'h7);
    step(0, 0, 0, '0, 0, '0);
    step(0, 0, 0, '0, 1, '0);
    drain(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) == 0) ||
            ((m_st == ST_HALT) && (m_cnt == 0) && ($urandom_range(0, 3) == 0));
      cor = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      step(rst, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15),
           4'($urandom), ($urandom_range(0, 99) < 35), cor);
    end
    drain(DEPTH + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pro3_do_reader.md
# pro3_do_reader

Receive-side companion to the Pro_3 data-register FSM. It observes the register's write controls (LOAD, NOT, DATA) and its output DO on a single clock. It captures every new DO word into a small FIFO for a downstream consumer, and can optionally check DO against a reference model of the register. It sits directly on the Pro_3 output bus.

## Interface
Parameters:
- WIDTH, 4: data word width; must match Pro_3 DATA/DO.
- DEPTH, 4: FIFO depth; power of two, ≥2.

Ports:
- clka  input  1  system clock; all logic on rising edge.
- RESTART  input  1  synchronous, active-high reset.
- LOAD  input  1  mirror of the Pro_3 load control.
- NOT  input  1  mirror of the Pro_3 invert control.
- DATA  input  WIDTH  mirror of the Pro_3 load data.
- DO  input  WIDTH  Pro_3 registered output.
- RD  input  1  pop request; ignored when EMPTY.
- Q  output  WIDTH  FIFO head word; 0 when EMPTY.
- EMPTY  output  1  FIFO empty.
- FULL  output  1  FIFO holds DEPTH words.
- CNT  output  log2(DEPTH)+1  words currently held.
- OVF  output  1  sticky overflow flag.
- r_state  output  2  reader state code.
- ERR  output  1  sticky mismatch flag (CHECK_EN only).
- ERR_CNT  output  4  saturating mismatch count (CHECK_EN only).

## Operation
- States:
  - IDLE = 00: entered on reset; moves unconditionally to SYNC on the next edge.
  - SYNC = 01: waits for LOAD=1 sampled at an edge, then moves to RUN.
  - RUN = 10: capture mode.
  - HALT = 11: entered on overflow; exited only by RESTART.
- Capture in RUN:
  - The first RUN cycle pushes DO unconditionally.
  - After that, a push happens whenever sampled DO ≠ last_do (the last pushed word).
  - last_do updates only on an accepted push.
- Pop:
  - When RD=1 and EMPTY=0, the head is removed at the edge.
  - Q then shows the next word in the same cycle the pointer updates.
- Simultaneous push and pop:
  - When FULL: both occur, CNT is unchanged, no overflow.
  - When EMPTY: the pop is ignored, the push is accepted, CNT becomes 1.
- Overflow: a push while FULL with no pop drops the word, sets OVF=1, and moves to HALT.
- HALT:
  - No pushes.
  - Pops still work, so stored data stays drainable.
  - OVF stays 1.
- Pointers wrap modulo DEPTH.
- CNT ranges 0..DEPTH. FULL = (CNT==DEPTH). EMPTY = (CNT==0).
- RESTART=1 at any edge, including mid-capture or in HALT, produces the following at that edge:
  - Pointers, CNT, last_do, OVF, ERR and ERR_CNT are cleared.
  - r_state becomes IDLE.
  - FIFO contents are discarded.
- Reset values:
  - Q=0, EMPTY=1, FULL=0, CNT=0, OVF=0, r_state=00, ERR=0, ERR_CNT=0.

## Timing
- DO is the Pro_3 registered output: controls sampled at edge n appear on DO before edge n+1.
- Push latency:
  - A DO change sampled at edge k is written at edge k.
  - The word is visible on Q (if the FIFO was empty) and in CNT after edge k.
- FIFO flags and CNT are registered. Q is a combinational read of the head entry.
- SYNC→RUN: LOAD sampled at edge k moves to RUN at edge k. The unconditional first push is at edge k+1, capturing the loaded DATA.
- The check model (see Configuration) compares at edge n+1 against the expectation formed at edge n, so there is one cycle of model latency.

## Configuration
- CHECK_EN defined:
  - exp register, WIDTH bits: on each edge, LOAD=1 sets exp<=DATA; otherwise NOT=1 sets exp<=~exp; otherwise exp holds. LOAD has priority over NOT.
  - armed flag: set at the first edge with LOAD=1.
  - Comparison: at every edge where armed was already 1, DO≠exp sets ERR=1 (sticky) and increments ERR_CNT, saturating at 15.
  - The checker runs in every state except IDLE.
- CHECK_EN undefined: the exp and armed logic is absent. ERR and ERR_CNT are tied to 0.

## Test plan
- Reset: hold RESTART=1 for 2 edges with random inputs → Q=0, EMPTY=1, FULL=0, CNT=0, OVF=0, r_state=00, ERR=0.
- Basic capture:
  - Stimulus: release reset, LOAD=1 with DATA=5, DO=5 on the next cycle.
  - Response: r_state=10, CNT=1, Q=5. DO held at 5 for 3 more edges keeps CNT=1.
- Invert sequence:
  - Stimulus: DO goes 5→A→5 on consecutive edges, then RD=1 for 3 edges.
  - Response: the entries 5, A, 5 are captured, then Q reads 5, A, 5 in order. EMPTY=1 afterwards.
- Overflow (DEPTH=4): 5 distinct DO changes (1,2,3,4,6) with RD=0 → FULL=1, OVF=1, r_state=11, Q=1. Draining 4 pops gives 1,2,3,4, and the value 6 is lost.
- Full push/pop:
  - Stimulus: with CNT=4, a DO change arrives together with RD=1.
  - Response: CNT stays 4, OVF=0, and the new word lands at the tail.
- CHECK_EN:
  - Stimulus: LOAD=1 with DATA=3, then DO=4 on the next cycle.
  - Response: ERR=1, ERR_CNT=1. Next, NOT=1 with DO=~3=C gives no new error. Without the macro, ERR stays 0.
